// File: rtl/instr_encoder.sv
// Instruction encoder: packs MIPS-style fields into 32-bit words, stamps byte addresses,
// and buffers them in a 2-entry FIFO. Optional JAL encoding under INSTR_ENCODER_JAL_EN.
module instr_encoder #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clear_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [3:0]  op_sel_i,
  input  logic [4:0]  rs_i,
  input  logic [4:0]  rt_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  shamt_i,
  input  logic [5:0]  funct_i,
  input  logic [15:0] imm_i,
  input  logic [25:0] target_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_instr_o,
  output logic [31:0] out_addr_o,
  output logic        err_o,
  output logic [1:0]  count_o
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t      state_q;
  logic [31:0] head_instr_q, head_addr_q;
  logic [31:0] tail_instr_q, tail_addr_q;
  logic [31:0] addr_q;
  logic        err_q;
  logic        in_ready_q;

  logic [31:0] enc_word;
  logic        enc_legal;
  logic        push, push_legal, pop;
  logic        full_d;

  always_comb begin
    enc_legal = 1'b1;
    enc_word  = 32'h0;
    case (op_sel_i)
      4'd0:  enc_word = {6'd0, rs_i, rt_i, rd_i, shamt_i, funct_i};
      4'd1:  enc_word = {6'd1, rs_i, rt_i, imm_i};
      4'd2:  enc_word = {6'd4, rs_i, rt_i, imm_i};
      4'd3:  enc_word = {6'd5, rs_i, rt_i, imm_i};
      4'd4:  enc_word = {6'd6, rs_i, rt_i, imm_i};
      4'd5:  enc_word = {6'd8, rs_i, rt_i, imm_i};
      4'd6:  enc_word = {6'd9, rs_i, rt_i, imm_i};
      4'd7:  enc_word = {6'd13, rs_i, rt_i, imm_i};
      4'd8:  enc_word = {6'd15, rs_i, rt_i, imm_i};
      4'd9:  enc_word = {6'd2, target_i};
      4'd10: enc_word = {6'd35, rs_i, rt_i, imm_i};
      4'd11: enc_word = {6'd43, rs_i, rt_i, imm_i};
`ifdef INSTR_ENCODER_JAL_EN
      4'd12: enc_word = {6'd3, target_i};
`endif
      default: enc_legal = 1'b0;
    endcase
  end

  // clear_i gates the handshake so nothing is accepted during a flush
  assign in_ready_o  = in_ready_q & ~clear_i;
  assign out_valid_o = (state_q != EMPTY);
  assign push        = in_valid_i & in_ready_o;
  assign push_legal  = push & enc_legal;
  assign pop         = out_valid_o & out_ready_i;

  always_comb begin
    full_d = 1'b0;
    case (state_q)
      ONE:     full_d = push_legal & ~pop;
      FULL:    full_d = ~pop;
      default: full_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= EMPTY;
      head_instr_q <= 32'h0;
      head_addr_q  <= 32'h0;
      tail_instr_q <= 32'h0;
      tail_addr_q  <= 32'h0;
      addr_q       <= RESET_ADDR;
      err_q        <= 1'b0;
      in_ready_q   <= 1'b1;
    end else if (clear_i) begin
      state_q    <= EMPTY;
      addr_q     <= 32'h0;
      err_q      <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      err_q      <= push & ~enc_legal;
      in_ready_q <= ~full_d;
      if (push_legal) addr_q <= addr_q + 32'd4;
      case (state_q)
        EMPTY: begin
          if (push_legal) begin
            head_instr_q <= enc_word;
            head_addr_q  <= addr_q;
            state_q      <= ONE;
          end
        end
        ONE: begin
          if (push_legal && pop) begin
            head_instr_q <= enc_word;
            head_addr_q  <= addr_q;
          end else if (push_legal) begin
            tail_instr_q <= enc_word;
            tail_addr_q  <= addr_q;
            state_q      <= FULL;
          end else if (pop) begin
            state_q <= EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            head_instr_q <= tail_instr_q;
            head_addr_q  <= tail_addr_q;
            state_q      <= ONE;
          end
        end
        default: state_q <= EMPTY;
      endcase
    end
  end

  assign out_instr_o = head_instr_q;
  assign out_addr_o  = head_addr_q;
  assign err_o       = err_q;
  assign count_o     = state_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed self-checking bench for instr_encoder; a second instance with a preloaded
// address counter exercises the address wrap.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic [3:0]  op_sel = 4'd0;
  logic [4:0]  rs = 5'd0, rt = 5'd0, rd = 5'd0, shamt = 5'd0;
  logic [5:0]  funct = 6'd0;
  logic [15:0] imm = 16'd0;
  logic [25:0] target = 26'd0;
  logic        out_ready = 1'b0;

  logic        in_ready, out_valid, err;
  logic [31:0] out_instr, out_addr;
  logic [1:0]  count;
  logic        w_in_ready, w_out_valid, w_err;
  logic [31:0] w_out_instr, w_out_addr;
  logic [1:0]  w_count;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  instr_encoder dut (
    .clk_i(clk), .rst_i(rst_n), .clear_i(clear),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .op_sel_i(op_sel), .rs_i(rs), .rt_i(rt), .rd_i(rd), .shamt_i(shamt),
    .funct_i(funct), .imm_i(imm), .target_i(target),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_instr_o(out_instr), .out_addr_o(out_addr),
    .err_o(err), .count_o(count)
  );

  instr_encoder #(.RESET_ADDR(32'hFFFF_FFFC)) dut_wrap (
    .clk_i(clk), .rst_i(rst_n), .clear_i(clear),
    .in_valid_i(in_valid), .in_ready_o(w_in_ready),
    .op_sel_i(op_sel), .rs_i(rs), .rt_i(rt), .rd_i(rd), .shamt_i(shamt),
    .funct_i(funct), .imm_i(imm), .target_i(target),
    .out_valid_o(w_out_valid), .out_ready_i(out_ready),
    .out_instr_o(w_out_instr), .out_addr_o(w_out_addr),
    .err_o(w_err), .count_o(w_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
      $display("check %s observed=%h expected=%h ok", tag, obs, exp);
    end else begin
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [3:0] op, input logic [4:0] s, input logic [4:0] t,
                     input logic [4:0] d, input logic [5:0] f, input logic [15:0] im,
                     input logic [25:0] tg);
    op_sel = op; rs = s; rt = t; rd = d; shamt = 5'd0; funct = f; imm = im; target = tg;
    in_valid = 1'b1;
  endtask

  task automatic do_clear();
    in_valid = 1'b0;
    clear = 1'b1;
    cyc();
    clear = 1'b0;
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_count", {30'd0, count}, 32'd0);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_instr", out_instr, 32'd0);
    chk("rst_addr", out_addr, 32'd0);
    cyc();
    rst_n = 1'b1;
    cyc();
    chk("rst_ready", {31'd0, in_ready}, 32'd1);

    // ADDI single word
    out_ready = 1'b1;
    req(4'd5, 5'd1, 5'd2, 5'd0, 6'd0, 16'h0005, 26'd0);
    cyc();
    in_valid = 1'b0;
    chk("addi_valid", {31'd0, out_valid}, 32'd1);
    chk("addi_instr", out_instr, 32'h2022_0005);
    chk("addi_addr", out_addr, 32'h0);
    cyc();
    chk("addi_drain", {30'd0, count}, 32'd0);

    // RTYPE then BEQ, push+pop at count 1
    do_clear();
    req(4'd0, 5'd1, 5'd2, 5'd3, 6'h20, 16'h0, 26'd0);
    cyc();
    chk("rtype_instr", out_instr, 32'h0022_1820);
    chk("rtype_addr", out_addr, 32'h0);
    req(4'd2, 5'd1, 5'd2, 5'd0, 6'd0, 16'hFFFF, 26'd0);
    cyc();
    in_valid = 1'b0;
    chk("beq_count", {30'd0, count}, 32'd1);
    chk("beq_instr", out_instr, 32'h1022_FFFF);
    chk("beq_addr", out_addr, 32'h4);
    cyc();
    chk("beq_drain", {30'd0, count}, 32'd0);

    // Backpressure: three pushes with out_ready low
    do_clear();
    out_ready = 1'b0;
    req(4'd10, 5'd3, 5'd4, 5'd0, 6'd0, 16'h0010, 26'd0);
    cyc();
    chk("bp_count1", {30'd0, count}, 32'd1);
    req(4'd11, 5'd3, 5'd5, 5'd0, 6'd0, 16'h0020, 26'd0);
    cyc();
    chk("bp_count2", {30'd0, count}, 32'd2);
    chk("bp_ready_low", {31'd0, in_ready}, 32'd0);
    req(4'd7, 5'd6, 5'd7, 5'd0, 6'd0, 16'h00FF, 26'd0);
    cyc();
    chk("bp_held_count", {30'd0, count}, 32'd2);
    chk("bp_head_stable", out_instr, 32'h8C64_0010);
    chk("bp_head_addr", out_addr, 32'h0);
    out_ready = 1'b1;
    cyc();
    chk("bp_pop1_count", {30'd0, count}, 32'd1);
    chk("bp_w1_instr", out_instr, 32'hAC65_0020);
    chk("bp_w1_addr", out_addr, 32'h4);
    cyc();
    in_valid = 1'b0;
    chk("bp_w2_instr", out_instr, 32'h34C7_00FF);
    chk("bp_w2_addr", out_addr, 32'h8);
    cyc();
    chk("bp_drain", {30'd0, count}, 32'd0);

    // Illegal op 14
    do_clear();
    req(4'd14, 5'd1, 5'd2, 5'd3, 6'd0, 16'h1234, 26'd0);
    cyc();
    in_valid = 1'b0;
    chk("ill_err", {31'd0, err}, 32'd1);
    chk("ill_novalid", {31'd0, out_valid}, 32'd0);
    cyc();
    chk("ill_err_pulse", {31'd0, err}, 32'd0);
    req(4'd5, 5'd1, 5'd2, 5'd0, 6'd0, 16'h0005, 26'd0);
    cyc();
    in_valid = 1'b0;
    chk("ill_next_addr", out_addr, 32'h0);
    chk("ill_next_err", {31'd0, err}, 32'd0);
    cyc();

    // JAL (configuration dependent)
    do_clear();
    req(4'd12, 5'd0, 5'd0, 5'd0, 6'd0, 16'h0, 26'h0000100);
    cyc();
    in_valid = 1'b0;
`ifdef INSTR_ENCODER_JAL_EN
    chk("jal_instr", out_instr, 32'h0C00_0100);
    chk("jal_err", {31'd0, err}, 32'd0);
`else
    chk("jal_err", {31'd0, err}, 32'd1);
    chk("jal_novalid", {31'd0, out_valid}, 32'd0);
`endif
    cyc();

    // J, LUI, BLT encodings
    do_clear();
    req(4'd9, 5'd0, 5'd0, 5'd0, 6'd0, 16'h0, 26'h3FFFFFF);
    cyc();
    chk("j_instr", out_instr, 32'h0BFF_FFFF);
    req(4'd8, 5'd0, 5'd8, 5'd0, 6'd0, 16'h1234, 26'd0);
    cyc();
    chk("lui_instr", out_instr, 32'h3C08_1234);
    chk("lui_addr", out_addr, 32'h4);
    req(4'd1, 5'd2, 5'd3, 5'd0, 6'd0, 16'h0010, 26'd0);
    cyc();
    in_valid = 1'b0;
    chk("blt_instr", out_instr, 32'h0443_0010);
    cyc();

    // Clear with two buffered plus simultaneous push
    do_clear();
    out_ready = 1'b0;
    req(4'd5, 5'd1, 5'd2, 5'd0, 6'd0, 16'h0001, 26'd0);
    cyc();
    req(4'd5, 5'd1, 5'd2, 5'd0, 6'd0, 16'h0002, 26'd0);
    cyc();
    chk("clr_pre_count", {30'd0, count}, 32'd2);
    clear = 1'b1;
    req(4'd5, 5'd1, 5'd2, 5'd0, 6'd0, 16'h0003, 26'd0);
    #1;
    chk("clr_ready_low", {31'd0, in_ready}, 32'd0);
    cyc();
    clear = 1'b0;
    chk("clr_count", {30'd0, count}, 32'd0);
    chk("clr_novalid", {31'd0, out_valid}, 32'd0);
    req(4'd5, 5'd1, 5'd2, 5'd0, 6'd0, 16'h0004, 26'd0);
    cyc();
    in_valid = 1'b0;
    chk("clr_next_addr", out_addr, 32'h0);
    chk("clr_next_instr", out_instr, 32'h2022_0004);

    // Reset mid-transfer discards buffer
    req(4'd5, 5'd1, 5'd2, 5'd0, 6'd0, 16'h0005, 26'd0);
    cyc();
    in_valid = 1'b0;
    chk("mid_pre_count", {30'd0, count}, 32'd2);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_instr", out_instr, 32'd0);
    cyc();
    rst_n = 1'b1;
    cyc();
    chk("mid_post_count", {30'd0, count}, 32'd0);
    chk("mid_post_ready", {31'd0, in_ready}, 32'd1);

    // Address wrap on the preloaded instance
    out_ready = 1'b1;
    req(4'd5, 5'd1, 5'd2, 5'd0, 6'd0, 16'h0005, 26'd0);
    cyc();
    chk("wrap_addr0", w_out_addr, 32'hFFFF_FFFC);
    chk("wrap_main_addr0", out_addr, 32'h0);
    req(4'd2, 5'd1, 5'd2, 5'd0, 6'd0, 16'hFFFF, 26'd0);
    cyc();
    in_valid = 1'b0;
    chk("wrap_addr1", w_out_addr, 32'h0);
    chk("wrap_instr1", w_out_instr, 32'h1022_FFFF);
    cyc();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
